pipeline_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline. It merges three inputs into per-stage register enables and flushes:
- the ID-stage load-use stall request from the hazard unit;
- the EX-stage branch/jump redirect;
- the MEM-stage data-memory ready handshake.

It also owns halt sequencing, a data-memory timeout, and a stall performance counter. It sits in ID alongside the hazard unit and drives the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register.

---
 rtl/pipeline_ctrl_pkg.sv | 51 +++++
 rtl/pipeline_ctrl_if.sv | 39 +++
 rtl/pipeline_ctrl_sat_counter.sv | 29 ++
 rtl/pipeline_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline stall/flush sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
        logic memwb_flush;
    } stage_ctrl_t;

    localparam int c_mem_timeout_default = 64;

    localparam stage_ctrl_t c_ctrl_run        = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam stage_ctrl_t c_ctrl_load_use   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam stage_ctrl_t c_ctrl_redirect   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam stage_ctrl_t c_ctrl_freeze     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam stage_ctrl_t c_ctrl_halt_entry = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam stage_ctrl_t c_ctrl_halted     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Timeout counter must be able to hold MEM_TIMEOUT itself.
    function automatic int tmo_width(input int mem_timeout);
        return $clog2(mem_timeout + 1);
    endfunction

    // Redirect squashes the stalled ID instruction, so it outranks load-use.
    function automatic stage_ctrl_t advance_ctrl(input logic redirect, input logic load_use);
        if (redirect)
            return c_ctrl_redirect;
        else if (load_use)
            return c_ctrl_load_use;
        else
            return c_ctrl_run;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Hazard/memory requests in, per-stage enables and status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             load_use_stall;
    logic             redirect_EX;
    logic             dmem_req_MEM;
    logic             dmem_ready;
    logic             halt_WB;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_en;
    logic             memwb_flush;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output load_use_stall, redirect_EX, dmem_req_MEM, dmem_ready, halt_WB,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               memwb_en, memwb_flush, halted, mem_err, stall_cycles
    );

    modport slave (
        input  load_use_stall, redirect_EX, dmem_req_MEM, dmem_ready, halt_WB,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               memwb_en, memwb_flush, halted, mem_err, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_inc && !(&r_count))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall/flush sequencer merging load-use, redirect and dmem wait.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = c_mem_timeout_default
) (
    input  logic           clk,
    input  logic           rst_n,
    pipeline_ctrl_if.slave bus
);
    localparam int                 c_tmo_w     = tmo_width(MEM_TIMEOUT);
    localparam logic [c_tmo_w-1:0] c_tmo_limit = c_tmo_w'(MEM_TIMEOUT);
    localparam logic [c_tmo_w-1:0] c_tmo_one   = c_tmo_w'(1);

    ctrl_state_t        r_state;
    ctrl_state_t        w_next_state;
    logic [c_tmo_w-1:0] r_tmo;
    logic [c_tmo_w-1:0] w_tmo_next;
    logic [c_tmo_w-1:0] w_tmo_inc;
    logic               r_mem_err;
    logic               w_mem_err_set;
    stage_ctrl_t        w_ctrl;
    logic               w_stall_inc;
    logic [CNT_W-1:0]   w_stall_cycles;

    assign w_tmo_inc = r_tmo + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_tmo     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_tmo   <= w_tmo_next;
            if (w_mem_err_set)
                r_mem_err <= 1'b1;
        end
    end

    always_comb begin
        w_ctrl        = c_ctrl_run;
        w_next_state  = r_state;
        w_tmo_next    = r_tmo;
        w_mem_err_set = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.halt_WB) begin
                    w_ctrl       = c_ctrl_halt_entry;
                    w_next_state = ST_HALT;
                end else if (bus.dmem_req_MEM && !bus.dmem_ready) begin
                    w_ctrl       = c_ctrl_freeze;
                    w_next_state = ST_MEM_WAIT;
                    w_tmo_next   = c_tmo_one;
                end else begin
                    w_ctrl = advance_ctrl(bus.redirect_EX, bus.load_use_stall);
                end
            end
            ST_MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    // Requests held frozen during the wait take effect on release.
                    w_ctrl       = advance_ctrl(bus.redirect_EX, bus.load_use_stall);
                    w_next_state = ST_RUN;
                    w_tmo_next   = '0;
                end else begin
                    w_ctrl = c_ctrl_freeze;
                    if (w_tmo_inc == c_tmo_limit) begin
                        w_mem_err_set = 1'b1;
                        w_next_state  = ST_HALT;
                        w_tmo_next    = '0;
                    end else begin
                        w_tmo_next = w_tmo_inc;
                    end
                end
            end
            ST_HALT: begin
                w_ctrl = c_ctrl_halted;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
        if (!rst_n)
            w_ctrl = c_ctrl_run;
    end

    assign w_stall_inc = !w_ctrl.pc_en && (r_state != ST_HALT);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_stall_inc),
        .i_clear (1'b0),
        .o_count (w_stall_cycles)
    );

    assign bus.pc_en        = w_ctrl.pc_en;
    assign bus.ifid_en      = w_ctrl.ifid_en;
    assign bus.ifid_flush   = w_ctrl.ifid_flush;
    assign bus.idex_en      = w_ctrl.idex_en;
    assign bus.idex_flush   = w_ctrl.idex_flush;
    assign bus.exmem_en     = w_ctrl.exmem_en;
    assign bus.memwb_en     = w_ctrl.memwb_en;
    assign bus.memwb_flush  = w_ctrl.memwb_flush;
    assign bus.halted       = (r_state == ST_HALT);
    assign bus.mem_err      = r_mem_err;
    assign bus.stall_cycles = w_stall_cycles;
endmodule
`default_nettype wire
